// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: FSM states,
// frame header and word geometry.
package uart_imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [7:0] HEADER         = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

    // Running payload checksum: plain modulo-256 byte sum.
    function automatic logic [7:0] add_byte(input logic [7:0] sum, input logic [7:0] b);
        return 8'(sum + b);
    endfunction

endpackage

// File: rtl/uart_imem_loader.sv
// Receives a framed program image over a UART byte stream and writes it into
// instruction memory word by word, holding the CPU until a good load completes.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam int              DEPTH     = 2 ** ADDR_WIDTH;
    localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int              BIDX_W    = $clog2(BYTES_PER_WORD);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

    state_t                state, state_next;
    logic [7:0]            len, len_next;
    logic [7:0]            word_cnt, word_cnt_next;
    logic [BIDX_W-1:0]     byte_idx, byte_idx_next;
    logic [7:0]            chk, chk_next;
    logic [TMO_W-1:0]      tmo_cnt, tmo_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  we_next;
    logic                  hold_next, done_next, err_next;
    logic                  tmo_run, tmo_hit, len_ok, last_word;

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_next    = state;
        len_next      = len;
        word_cnt_next = word_cnt;
        byte_idx_next = byte_idx;
        chk_next      = chk;
        addr_next     = mem_addr;
        data_next     = mem_data;
        we_next       = 1'b0;

        tmo_run   = (state == LEN) || (state == DATA) || (state == CHK);
        tmo_next  = (tmo_run && !rx_valid) ? TMO_W'(tmo_cnt + TMO_W'(1)) : '0;
        tmo_hit   = tmo_run && !rx_valid && (tmo_next == TMO_LIMIT);
        len_ok    = (rx_data != 8'd0) && (32'(rx_data) <= 32'(DEPTH));
        last_word = (8'(word_cnt + 8'd1) == len);

        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == HEADER)) begin
                    state_next    = LEN;
                    addr_next     = '0;
                    word_cnt_next = 8'd0;
                    byte_idx_next = '0;
                    chk_next      = 8'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if (len_ok) begin
                        len_next   = rx_data;
                        state_next = DATA;
                    end else begin
                        state_next = ERR;
                    end
                end else if (tmo_hit) begin
                    state_next = ERR;
                end else begin
                    state_next = LEN;
                end
            end
            DATA: begin
                // The write pulse of the last word is the final DATA cycle.
                if (mem_we) begin
                    addr_next     = ADDR_WIDTH'(mem_addr + ADDR_WIDTH'(1));
                    word_cnt_next = 8'(word_cnt + 8'd1);
                end else begin
                    addr_next = mem_addr;
                end
                if (mem_we && last_word) begin
                    state_next = CHK;
                end else if (rx_valid) begin
                    data_next[{byte_idx, 3'b000} +: 8] = rx_data;
                    chk_next      = add_byte(chk, rx_data);
                    byte_idx_next = BIDX_W'(byte_idx + BIDX_W'(1));
                    we_next       = (byte_idx == LAST_BYTE);
                end else if (tmo_hit) begin
                    state_next = ERR;
                end else begin
                    state_next = DATA;
                end
            end
            CHK: begin
                if (rx_valid) begin
                    state_next = (rx_data == chk) ? DONE : ERR;
                end else if (tmo_hit) begin
                    state_next = ERR;
                end else begin
                    state_next = CHK;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            ERR: begin
                if (rx_valid && (rx_data == HEADER)) begin
                    state_next    = LEN;
                    addr_next     = '0;
                    word_cnt_next = 8'd0;
                    byte_idx_next = '0;
                    chk_next      = 8'd0;
                end else begin
                    state_next = ERR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        hold_next = (state_next != DONE);
        done_next = (state_next == DONE);
        err_next  = (state_next == ERR);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len      <= 8'd0;
            word_cnt <= 8'd0;
            byte_idx <= '0;
            chk      <= 8'd0;
            tmo_cnt  <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            len      <= len_next;
            word_cnt <= word_cnt_next;
            byte_idx <= byte_idx_next;
            chk      <= chk_next;
            tmo_cnt  <= tmo_next;
            mem_addr <= addr_next;
            mem_data <= data_next;
            mem_we   <= we_next;
            cpu_hold <= hold_next;
            done     <= done_next;
            err      <= err_next;
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed and randomized frames
// compared against a frame-level reference model.
module tb_uart_imem_loader;

    localparam int AW  = 6;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          mem_we;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];

    always #5 clk = ~clk;

    uart_imem_loader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we(mem_we),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err)
    );

    // Record every memory write seen on the bus.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(2, 6)) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_data"}, mem_data, 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Sends a full frame; chk_sel<0 sends the correct checksum, else chk_sel.
    task automatic run_frame(input string tag, input logic [31:0] words[$], input int chk_sel);
        logic [7:0] sum;
        logic [7:0] last;
        bit         good;
        int         n;
        n   = words.size();
        sum = 8'd0;
        wr_addr_q.delete();
        wr_data_q.delete();
        send(8'hA5);
        chk({tag, "_hdr_err"}, 32'(err), 32'd0);
        chk({tag, "_hdr_hold"}, 32'(cpu_hold), 32'd1);
        send(8'(n));
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                sum = 8'(sum + words[i][8*k +: 8]);
                send(words[i][8*k +: 8]);
            end
        end
        last = (chk_sel < 0) ? sum : 8'(chk_sel);
        good = (last == sum);
        send(last);
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            chk({tag, "_waddr"}, 32'(wr_addr_q[i]), 32'(i));
            chk({tag, "_wdata"}, wr_data_q[i], words[i]);
        end
        chk({tag, "_done"}, 32'(done), 32'(good));
        chk({tag, "_err"}, 32'(err), 32'(!good));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(!good));
    endtask

    initial begin
        logic [31:0] words[$];
        logic [7:0]  junk;
        int          n;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);

        // Reset state
        do_reset();
        chk_reset_outputs("reset");

        // Known-good two-word frame, then DONE ignores further bytes
        words = '{32'h0000_0013, 32'h0010_0093};
        run_frame("good", words, -1);
        wr_addr_q.delete();
        send(8'hA5);
        send(8'h01);
        send(8'h13);
        repeat (5) @(negedge clk);
        chk("done_sticky", 32'(done), 32'd1);
        chk("done_hold", 32'(cpu_hold), 32'd0);
        chk("done_nowrite", 32'(wr_addr_q.size()), 32'd0);

        // Same frame with a bad checksum byte, then recovery
        do_reset();
        run_frame("badchk", words, 8'h00);
        words = '{$urandom()};
        run_frame("recover", words, -1);

        // Length bounds
        do_reset();
        send(8'hA5);
        send(8'h00);
        repeat (3) @(negedge clk);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_done", 32'(done), 32'd0);
        chk("len0_nowrite", 32'(wr_addr_q.size()), 32'd0);
        do_reset();
        send(8'hA5);
        send(8'h41);
        repeat (3) @(negedge clk);
        chk("len41_err", 32'(err), 32'd1);
        chk("len41_nowrite", 32'(wr_addr_q.size()), 32'd0);
        do_reset();
        words.delete();
        for (int i = 0; i < 64; i++) words.push_back($urandom());
        run_frame("len40", words, -1);

        // Randomized frames with junk bytes in IDLE
        for (int f = 0; f < 6; f++) begin
            do_reset();
            for (int j = 0; j < 3; j++) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h00;
                send(junk);
            end
            chk("junk_err", 32'(err), 32'd0);
            chk("junk_nowrite", 32'(wr_addr_q.size()), 32'd0);
            n = $urandom_range(1, 8);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom());
            run_frame("rand", words, (f % 2 == 1) ? $urandom_range(0, 255) : -1);
        end

        // Inter-byte timeout
        do_reset();
        send(8'hA5);
        send(8'h01);
        send(8'h13);
        repeat (40) @(negedge clk);
        chk("tmo_early_err", 32'(err), 32'd0);
        repeat (60) @(negedge clk);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_hold", 32'(cpu_hold), 32'd1);
        chk("tmo_nowrite", 32'(wr_addr_q.size()), 32'd0);

        // Reset mid-frame, coinciding with a payload byte
        do_reset();
        send(8'hA5);
        send(8'h01);
        send(8'h13);
        send(8'h00);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        @(negedge clk);
        rx_valid = 1'b0;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        send(8'h00);
        repeat (10) @(negedge clk);
        chk("midrst_nowrite", 32'(wr_addr_q.size()), 32'd0);
        chk_reset_outputs("midrst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
